// File: rtl/flash_pkg.sv
//------------------------------------------------------------------------------
// Module  : flash_pkg
// Brief   : Shared FSM encoding and default sample-region bounds for the
//           flash sample reader.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package flash_pkg;

  localparam int unsigned FLASH_ADDR_W     = 23;
  localparam logic [22:0] FLASH_START_ADDR = 23'h000000;
  localparam logic [22:0] FLASH_END_ADDR   = 23'h07FFFF;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_REQ       = 2'd1,
    ST_WAIT_DATA = 2'd2,
    ST_EMIT      = 2'd3
  } state_e;

endpackage

`default_nettype wire

// File: rtl/flash_sample_reader_if.sv
//------------------------------------------------------------------------------
// Module  : flash_sample_reader_if
// Brief   : Avalon-MM read-only bus between the sample reader and flash.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface flash_sample_reader_if #(
  parameter int unsigned ADDR_W = 23
);
  logic              flash_mem_read;
  logic [ADDR_W-1:0] flash_mem_address;
  logic [3:0]        flash_mem_byteenable;
  logic              flash_mem_waitrequest;
  logic [31:0]       flash_mem_readdata;
  logic              flash_mem_readdatavalid;

  modport master (
    output flash_mem_read, flash_mem_address, flash_mem_byteenable,
    input  flash_mem_waitrequest, flash_mem_readdata, flash_mem_readdatavalid
  );

  modport slave (
    input  flash_mem_read, flash_mem_address, flash_mem_byteenable,
    output flash_mem_waitrequest, flash_mem_readdata, flash_mem_readdatavalid
  );
endinterface

`default_nettype wire

// File: rtl/sample_addr_gen.sv
//------------------------------------------------------------------------------
// Module  : sample_addr_gen
// Brief   : Flash word-address register with step/wrap and restart rewind.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sample_addr_gen import flash_pkg::*; #(
  parameter int unsigned       ADDR_W     = FLASH_ADDR_W,
  parameter logic [ADDR_W-1:0] START_ADDR = ADDR_W'(FLASH_START_ADDR),
  parameter logic [ADDR_W-1:0] END_ADDR   = ADDR_W'(FLASH_END_ADDR)
) (
  input  logic              inclk,
  input  logic              reset_n,
  input  logic              advance_i,
  input  logic              adv_dir_i,
  input  logic              restart_i,
  input  logic              restart_dir_i,
  output logic [ADDR_W-1:0] addr_o
);

  logic [ADDR_W-1:0] addr_q, addr_d;

  // Restart wins over a same-cycle advance.
  always_comb begin
    addr_d = addr_q;
    if (restart_i) begin
      addr_d = restart_dir_i ? START_ADDR : END_ADDR;
    end else if (advance_i) begin
      if (adv_dir_i) begin
        addr_d = (addr_q == END_ADDR) ? START_ADDR : addr_q + ADDR_W'(1);
      end else begin
        addr_d = (addr_q == START_ADDR) ? END_ADDR : addr_q - ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge inclk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q <= START_ADDR;
    end else begin
      addr_q <= addr_d;
    end
  end

  assign addr_o = addr_q;

endmodule

`default_nettype wire

// File: rtl/flash_sample_reader.sv
//------------------------------------------------------------------------------
// Module  : flash_sample_reader
// Brief   : Streams 16-bit samples out of 32-bit flash words on demand.
//           Optional macro OVERRUN_CNT_EN enables the dropped-tick counter.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module flash_sample_reader import flash_pkg::*; #(
  parameter int unsigned       ADDR_W     = FLASH_ADDR_W,
  parameter logic [ADDR_W-1:0] START_ADDR = ADDR_W'(FLASH_START_ADDR),
  parameter logic [ADDR_W-1:0] END_ADDR   = ADDR_W'(FLASH_END_ADDR)
) (
  input  logic                          inclk,
  input  logic                          reset_n,
  input  logic                          sample_tick,
  input  logic                          play_en,
  input  logic                          direction,
  input  logic                          restart,
  flash_sample_reader_if.master         avm,
  output logic [15:0]                   sample_out,
  output logic                          sample_valid,
  output logic                          busy,
  output logic [15:0]                   overrun_count
);

  state_e      state_q, state_d;
  logic        buf_valid_q, buf_valid_d;
  logic [15:0] buf_q, buf_d;
  logic        buf_dir_q, buf_dir_d;
  logic        fetch_dir_q, fetch_dir_d;
  logic        pend_q, pend_d;
  logic        rst_pend_q, rst_pend_d;
  logic        rst_dir_q, rst_dir_d;
  logic [15:0] sample_q, sample_d;

  logic tick_acc, serve, apply_rst, adv, rs, rs_dir;
  logic [ADDR_W-1:0] addr;

  assign tick_acc = sample_tick & play_en;

  always_comb begin
    state_d     = state_q;
    buf_valid_d = buf_valid_q;
    buf_d       = buf_q;
    buf_dir_d   = buf_dir_q;
    fetch_dir_d = fetch_dir_q;
    pend_d      = pend_q;
    rst_pend_d  = rst_pend_q;
    rst_dir_d   = rst_dir_q;
    sample_d    = sample_q;
    adv         = 1'b0;
    rs          = 1'b0;
    rs_dir      = direction;
    serve       = 1'b0;
    apply_rst   = 1'b0;

    if (state_q == ST_IDLE) begin
      if (restart) begin
        rs          = 1'b1;
        buf_valid_d = 1'b0;
        pend_d      = 1'b0;
      end
      serve = tick_acc | (pend_q & ~restart);
      if (serve) begin
        // A fresh tick arriving alongside a pending one stays parked.
        pend_d = tick_acc & pend_q & ~restart;
        if (buf_valid_q & ~restart) begin
          sample_d    = buf_q;
          buf_valid_d = 1'b0;
          adv         = 1'b1;
          state_d     = ST_EMIT;
        end else begin
          fetch_dir_d = direction;
          state_d     = ST_REQ;
        end
      end
    end else begin
      if (restart) begin
        rst_pend_d = 1'b1;
        rst_dir_d  = direction;
        pend_d     = 1'b0;
      end
      if (tick_acc) begin
        pend_d = 1'b1;
      end
      apply_rst = restart | rst_pend_q;
      case (state_q)
        ST_REQ: begin
          if (!avm.flash_mem_waitrequest) state_d = ST_WAIT_DATA;
        end
        ST_WAIT_DATA: begin
          if (avm.flash_mem_readdatavalid) begin
            if (apply_rst) begin
              state_d = ST_IDLE;
            end else begin
              sample_d    = fetch_dir_q ? avm.flash_mem_readdata[15:0]  : avm.flash_mem_readdata[31:16];
              buf_d       = fetch_dir_q ? avm.flash_mem_readdata[31:16] : avm.flash_mem_readdata[15:0];
              buf_valid_d = 1'b1;
              buf_dir_d   = fetch_dir_q;
              state_d     = ST_EMIT;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
      // A latched rewind takes effect only once the bus transaction is over.
      if (apply_rst && (state_d == ST_IDLE)) begin
        rs          = 1'b1;
        rs_dir      = restart ? direction : rst_dir_q;
        rst_pend_d  = 1'b0;
        buf_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge inclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      buf_valid_q <= 1'b0;
      buf_q       <= '0;
      buf_dir_q   <= 1'b1;
      fetch_dir_q <= 1'b1;
      pend_q      <= 1'b0;
      rst_pend_q  <= 1'b0;
      rst_dir_q   <= 1'b1;
      sample_q    <= '0;
    end else begin
      state_q     <= state_d;
      buf_valid_q <= buf_valid_d;
      buf_q       <= buf_d;
      buf_dir_q   <= buf_dir_d;
      fetch_dir_q <= fetch_dir_d;
      pend_q      <= pend_d;
      rst_pend_q  <= rst_pend_d;
      rst_dir_q   <= rst_dir_d;
      sample_q    <= sample_d;
    end
  end

  sample_addr_gen #(
    .ADDR_W     (ADDR_W),
    .START_ADDR (START_ADDR),
    .END_ADDR   (END_ADDR)
  ) u_addr_gen (
    .inclk         (inclk),
    .reset_n       (reset_n),
    .advance_i     (adv),
    .adv_dir_i     (buf_dir_q),
    .restart_i     (rs),
    .restart_dir_i (rs_dir),
    .addr_o        (addr)
  );

`ifdef OVERRUN_CNT_EN
  logic [15:0] ovr_q;
  logic        drop;

  assign drop = tick_acc & pend_q & ~restart & (state_q != ST_IDLE);

  always_ff @(posedge inclk or negedge reset_n) begin
    if (!reset_n) begin
      ovr_q <= '0;
    end else if (drop && (ovr_q != 16'hFFFF)) begin
      ovr_q <= ovr_q + 16'd1;
    end
  end

  assign overrun_count = ovr_q;
`else
  assign overrun_count = 16'h0000;
`endif

  assign avm.flash_mem_read       = (state_q == ST_REQ);
  assign avm.flash_mem_address    = addr;
  assign avm.flash_mem_byteenable = 4'b1111;
  assign sample_out               = sample_q;
  assign sample_valid             = (state_q == ST_EMIT);
  assign busy                     = (state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_flash_sample_reader.sv
//------------------------------------------------------------------------------
// Module  : tb_flash_sample_reader
// Brief   : Directed self-checking bench with a sample-stream reference model.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_flash_sample_reader;

  localparam int unsigned AW = 23;
  localparam logic [22:0] S  = 23'h000000;
  localparam logic [22:0] E  = 23'h07FFFF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tick = 1'b0;
  logic        play = 1'b1;
  logic        dir = 1'b1;
  logic        rs = 1'b0;
  logic [15:0] sample_out;
  logic        sample_valid;
  logic        busy;
  logic [15:0] overrun;

  int n_checks = 0;
  int n_fail   = 0;

  flash_sample_reader_if #(.ADDR_W(AW)) bus ();

  flash_sample_reader #(.ADDR_W(AW), .START_ADDR(S), .END_ADDR(E)) dut (
    .inclk         (clk),
    .reset_n       (rst_n),
    .sample_tick   (tick),
    .play_en       (play),
    .direction     (dir),
    .restart       (rs),
    .avm           (bus),
    .sample_out    (sample_out),
    .sample_valid  (sample_valid),
    .busy          (busy),
    .overrun_count (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [22:0] a);
    if (a == S) return 32'h2222_1111;
    if (a == E) return 32'hBBBB_AAAA;
    return {a[15:0] ^ 16'hC3C3, a[15:0] + 16'h0100};
  endfunction

  // Reference model: position in the sample stream
  logic [22:0] m_addr = S;
  bit          m_buf = 1'b0;
  logic        m_dir = 1'b1;
  logic [31:0] m_word = '0;
  int          n_valid = 0;
  int          n_read_cycles = 0;

  task automatic model_restart(input logic d);
    m_addr = d ? S : E;
    m_buf  = 1'b0;
  endtask

  // Avalon slave: configurable waitrequest stall, fixed read latency of two
  int          cfg_stall = 0;
  int          stall_left = 0;
  int          lat_cnt = 0;
  logic [22:0] lat_addr = '0;
  bit          was_read = 1'b0;

  initial begin
    bus.flash_mem_waitrequest   = 1'b0;
    bus.flash_mem_readdatavalid = 1'b0;
    bus.flash_mem_readdata      = '0;
    forever begin
      @(negedge clk);
      bus.flash_mem_readdatavalid = 1'b0;
      if (lat_cnt > 0) begin
        lat_cnt--;
        if (lat_cnt == 0) begin
          bus.flash_mem_readdatavalid = 1'b1;
          bus.flash_mem_readdata      = mem_word(lat_addr);
        end
      end
      if (bus.flash_mem_read) begin
        if (!was_read) stall_left = cfg_stall;
        if (stall_left > 0) begin
          bus.flash_mem_waitrequest = 1'b1;
          stall_left--;
        end else begin
          bus.flash_mem_waitrequest = 1'b0;
          lat_addr = bus.flash_mem_address;
          lat_cnt  = 2;
        end
        was_read = bus.flash_mem_waitrequest;
      end else begin
        bus.flash_mem_waitrequest = 1'b0;
        was_read = 1'b0;
      end
    end
  end

  // Compare process
  logic        prev_read = 1'b0;
  logic        prev_valid = 1'b0;
  logic [22:0] prev_addr = '0;

  initial begin
    logic [15:0] exp;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n) begin
        if (bus.flash_mem_read) n_read_cycles++;
        if (prev_read && bus.flash_mem_waitrequest) begin
          check("read_held", {31'd0, bus.flash_mem_read}, 32'd1);
          check("addr_held", {9'd0, bus.flash_mem_address}, {9'd0, prev_addr});
        end
        if (bus.flash_mem_read && !prev_read) begin
          check("fetch_addr", {9'd0, bus.flash_mem_address}, {9'd0, m_addr});
          check("fetch_buf_empty", {31'd0, m_buf}, 32'd0);
        end
        if (sample_valid) begin
          n_valid++;
          check("valid_pulse", {31'd0, prev_valid}, 32'd0);
          if (m_buf) begin
            exp = m_dir ? m_word[31:16] : m_word[15:0];
            if (m_dir) m_addr = (m_addr == E) ? S : m_addr + 23'd1;
            else       m_addr = (m_addr == S) ? E : m_addr - 23'd1;
            m_buf = 1'b0;
          end else begin
            m_word = mem_word(m_addr);
            m_dir  = dir;
            exp    = m_dir ? m_word[15:0] : m_word[31:16];
            m_buf  = 1'b1;
          end
          check("sample", {16'd0, sample_out}, {16'd0, exp});
        end
      end
      prev_read  = bus.flash_mem_read;
      prev_valid = sample_valid;
      prev_addr  = bus.flash_mem_address;
    end
  end

  task automatic do_tick();
    @(negedge clk); tick = 1'b1;
    @(negedge clk); tick = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    @(negedge clk);
    while (busy && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (busy) begin
      n_checks++;
      n_fail++;
      $display("FAIL idle_timeout: busy still %0d after %0d cycles", busy, k);
    end
  endtask

  task automatic tick_wait();
    do_tick();
    wait_idle();
    repeat (2) @(negedge clk);
  endtask

  task automatic restart_idle(input logic d);
    @(negedge clk); dir = d; rs = 1'b1;
    model_restart(d);
    @(negedge clk); rs = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int v0, r0, k;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_read", {31'd0, bus.flash_mem_read}, 32'd0);
    check("rst_addr", {9'd0, bus.flash_mem_address}, {9'd0, S});
    check("rst_sample", {16'd0, sample_out}, 32'd0);
    check("rst_valid", {31'd0, sample_valid}, 32'd0);
    check("rst_overrun", {16'd0, overrun}, 32'd0);
    check("byteenable", {28'd0, bus.flash_mem_byteenable}, 32'hF);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Forward word 0, ticks 40 cycles apart
    do_tick(); repeat (40) @(negedge clk);
    check("fwd_lo", {16'd0, sample_out}, 32'h1111);
    do_tick(); repeat (40) @(negedge clk);
    check("fwd_hi", {16'd0, sample_out}, 32'h2222);
    check("fwd_addr1", {9'd0, bus.flash_mem_address}, 32'd1);

    repeat (4) tick_wait();

    // Five-cycle waitrequest stall
    cfg_stall = 5;
    v0 = n_valid; r0 = n_read_cycles;
    tick_wait();
    check("stall_read_cycles", n_read_cycles - r0, 32'd6);
    check("stall_valids", n_valid - v0, 32'd1);

    // Three back-to-back ticks during a read
    cfg_stall = 3;
    tick_wait();
    v0 = n_valid;
    @(negedge clk); tick = 1'b1;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk); tick = 1'b0;
    repeat (100) @(negedge clk);
    check("burst_valids", n_valid - v0, 32'd2);
`ifdef OVERRUN_CNT_EN
    check("overrun", {16'd0, overrun}, 32'd1);
`else
    check("overrun", {16'd0, overrun}, 32'd0);
`endif
    check("burst_addr", {9'd0, bus.flash_mem_address}, 32'd5);

    // Restart while waiting for read data at address 5
    cfg_stall = 0;
    v0 = n_valid;
    @(negedge clk); tick = 1'b1;
    @(negedge clk); tick = 1'b0;
    k = 0;
    while (!bus.flash_mem_read && k < 50) begin @(negedge clk); k++; end
    while (bus.flash_mem_read && k < 50) begin @(negedge clk); k++; end
    rs = 1'b1;
    @(negedge clk); rs = 1'b0;
    wait_idle();
    check("rst_inflight_valids", n_valid - v0, 32'd0);
    check("rst_inflight_addr", {9'd0, bus.flash_mem_address}, {9'd0, S});
    model_restart(1'b1);
    tick_wait();
    check("rst_next_sample", {16'd0, sample_out}, 32'h1111);

    // Paused ticks are ignored
    play = 1'b0;
    v0 = n_valid;
    do_tick(); repeat (20) @(negedge clk);
    check("pause_valids", n_valid - v0, 32'd0);
    check("pause_addr", {9'd0, bus.flash_mem_address}, {9'd0, S});
    play = 1'b1;

    // Backward from END_ADDR
    restart_idle(1'b0);
    check("bwd_start", {9'd0, bus.flash_mem_address}, {9'd0, E});
    tick_wait();
    check("bwd_hi", {16'd0, sample_out}, 32'hBBBB);
    tick_wait();
    check("bwd_lo", {16'd0, sample_out}, 32'hAAAA);
    check("bwd_addr", {9'd0, bus.flash_mem_address}, {9'd0, E - 23'd1});

    // Forward wrap at END_ADDR
    restart_idle(1'b0);
    dir = 1'b1;
    tick_wait();
    check("fwrap_lo", {16'd0, sample_out}, 32'hAAAA);
    tick_wait();
    check("fwrap_hi", {16'd0, sample_out}, 32'hBBBB);
    check("fwrap_addr", {9'd0, bus.flash_mem_address}, {9'd0, S});

    // Backward wrap at START_ADDR
    restart_idle(1'b1);
    dir = 1'b0;
    tick_wait();
    check("bwrap_hi", {16'd0, sample_out}, 32'h2222);
    tick_wait();
    check("bwrap_addr", {9'd0, bus.flash_mem_address}, {9'd0, E});

    // Restart and tick in the same cycle with a half buffered
    tick_wait();
    @(negedge clk); dir = 1'b1; rs = 1'b1; tick = 1'b1;
    model_restart(1'b1);
    @(negedge clk); rs = 1'b0; tick = 1'b0;
    wait_idle();
    repeat (2) @(negedge clk);
    check("rst_tick_sample", {16'd0, sample_out}, 32'h1111);
    check("rst_tick_addr", {9'd0, bus.flash_mem_address}, {9'd0, S});

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
